// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write handshakes for inst_encoder.
// master drives requests and accepts writes; slave is the encoder.
interface inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_last, in_kind,
    output in_rs, in_rt, in_rd,
    output in_imm, in_target, mem_ready,
    input  in_ready, mem_we,
    input  mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_kind,
    input  in_rs, in_rt, in_rd,
    input  in_imm, in_target, mem_ready,
    output in_ready, mem_we,
    output mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs symbolic MIPS instructions into words, buffers them
// and writes them to consecutive instruction-memory addresses.
module inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  inst_encoder_if.slave     bus,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]       PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [31:0]       fifo [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              legal, empty, full;
  logic              accept, push, pop;

  assign rs  = bus.in_rs;
  assign rt  = bus.in_rt;
  assign rd  = bus.in_rd;
  assign imm = bus.in_imm;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // load_start wins over any handshake in the same cycle
  assign bus.in_ready  = (state == LOAD) && !full && !load_start;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal;
  assign bus.mem_we    = !empty && !load_start;
  assign pop           = bus.mem_we && bus.mem_ready;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = empty ? '0 : fifo[rd_ptr[PW-1:0]];
  assign done          = (state == DRAIN) && empty && !load_start;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (bus.in_kind)
      4'd0:  word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:  word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:  word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd3:  word = {6'h00, rs, 15'd0, 6'h08};
      4'd4:  word = {6'h08, rs, rt, imm};
      4'd5:  word = {6'h0A, rs, rt, imm};
      4'd6:  word = {6'h23, rs, rt, imm};
      4'd7:  word = {6'h2B, rs, rt, imm};
      4'd8:  word = {6'h04, rs, rt, imm};
      4'd9:  word = {6'h05, rs, rt, imm};
      4'd10: word = {6'h02, bus.in_target};
      4'd11: word = {6'h03, bus.in_target};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = IDLE;
      LOAD:    if (accept && bus.in_last) state_n = DRAIN;
      DRAIN:   if (empty) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (load_start) state_n = LOAD;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr   <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (load_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr   <= start_addr;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        addr   <= addr + ADDR_ONE;
        count  <= count + CNT_ONE;
      end
      // illegal mnemonic, or a write that wraps the address space
      if ((accept && !legal) || (pop && &addr)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a queue-based
// reference model of the encoder's program-loading behaviour.
module tb_inst_encoder;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam logic [35:0] ITAB =
    {6'h05, 6'h04, 6'h2B, 6'h23, 6'h0A, 6'h08};

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count;
  logic          done, err;

  inst_encoder_if #(.ADDR_W(AW)) bus ();

  inst_encoder #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .start_addr (start_addr),
    .bus        (bus),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  req_t prog[$];
  wr_t  exp_q[$];
  wr_t  wlog[$];
  int   idx, nwr;
  logic loading, drain_f, exp_err, stalled_prev;
  logic [7:0]  exp_addr, prev_a;
  logic [31:0] prev_d;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] enc(input req_t r);
    logic [35:0] t;
    logic [5:0]  fn;
    int          k;
    t   = ITAB;
    k   = int'(r.kind);
    enc = '0;
    if (k <= 3) begin
      fn = (k == 0) ? 6'h20 : (k == 1) ? 6'h22 :
           (k == 2) ? 6'h2A : 6'h08;
      if (k == 3) enc = {1'b1, 6'h00, r.rs, 15'd0, fn};
      else enc = {1'b1, 6'h00, r.rs, r.rt, r.rd, 5'd0, fn};
    end else if (k <= 9) begin
      enc = {1'b1, t[(k-4)*6 +: 6], r.rs, r.rt, r.imm};
    end else if (k <= 11) begin
      enc = {1'b1, (k == 10) ? 6'h02 : 6'h03, r.target};
    end
  endfunction

  function automatic req_t mk(input int kind, input int rs,
                              input int rt, input int rd,
                              input int imm, input int tgt);
    req_t r;
    r.kind   = 4'(kind);
    r.rs     = 5'(rs);
    r.rt     = 5'(rt);
    r.rd     = 5'(rd);
    r.imm    = 16'(imm);
    r.target = 26'(tgt);
    return r;
  endfunction

  function automatic req_t rnd_req(input bit legal_only);
    int k;
    if (!legal_only && ($urandom % 10 == 0)) k = 12 + $urandom % 4;
    else k = $urandom % 12;
    return mk(k, $urandom, $urandom, $urandom, $urandom, $urandom);
  endfunction

  task automatic drive(input req_t r, input bit last);
    bus.in_kind   = r.kind;
    bus.in_rs     = r.rs;
    bus.in_rt     = r.rt;
    bus.in_rd     = r.rd;
    bus.in_imm    = r.imm;
    bus.in_target = r.target;
    bus.in_last   = last;
  endtask

  // model step at the negedge: check, then apply this cycle's handshakes
  task automatic observe();
    logic [32:0] e;
    wr_t w;
    chk("in_ready", bus.in_ready, loading && exp_q.size() < DEPTH);
    chk("mem_we", bus.mem_we, exp_q.size() != 0);
    chk("count", count, nwr);
    chk("err", err, exp_err);
    chk("done", done, drain_f && exp_q.size() == 0);
    if (drain_f && exp_q.size() == 0) drain_f = 1'b0;
    if (stalled_prev)
      chk("stall_hold", {bus.mem_addr, bus.mem_wdata}, {prev_a, prev_d});
    stalled_prev = bus.mem_we && !bus.mem_ready;
    prev_a = bus.mem_addr;
    prev_d = bus.mem_wdata;
    if (bus.mem_we && bus.mem_ready && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("waddr", bus.mem_addr, w.a);
      chk("wdata", bus.mem_wdata, w.d);
      wlog.push_back(w);
      nwr++;
      if (w.a == 8'hFF) exp_err = 1'b1;
    end
    if (bus.in_valid && bus.in_ready && idx < prog.size()) begin
      e = enc(prog[idx]);
      if (e[32]) begin
        w.a = exp_addr;
        w.d = e[31:0];
        exp_q.push_back(w);
        exp_addr++;
      end else begin
        exp_err = 1'b1;
      end
      if (idx == prog.size() - 1) begin
        loading = 1'b0;
        drain_f = 1'b1;
      end
      idx++;
    end
  endtask

  task automatic run(input logic [7:0] sa, input int vpct,
                     input int rpct, input int stall);
    int cyc, post;
    exp_q.delete();
    wlog.delete();
    idx = 0; nwr = 0; exp_err = 1'b0; exp_addr = sa;
    loading = 1'b0; drain_f = 1'b0; stalled_prev = 1'b0;
    start_addr = sa;
    load_start = 1'b1;
    @(negedge clk);
    chk("ready_load_cycle", bus.in_ready, 0);
    @(posedge clk); #1;
    load_start = 1'b0;
    loading = 1'b1;
    cyc = 0; post = 0;
    while (cyc < 800 && post < 3) begin
      if (idx < prog.size()) begin
        drive(prog[idx], idx == prog.size() - 1);
        bus.in_valid = ($urandom % 100) < vpct;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.mem_ready = (cyc < stall) ? 1'b0 : (($urandom % 100) < rpct);
      @(negedge clk);
      observe();
      if (idx == prog.size() && exp_q.size() == 0 && !drain_f) post++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 800) chk("timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b0;
    chk("words_left", exp_q.size(), 0);
    chk("end_addr", bus.mem_addr, exp_addr);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 0, 0));
    prog.push_back(mk(6, 0, 4, 0, 8, 0));
    prog.push_back(mk(10, 0, 0, 0, 0, 'h40));
    run(8'h10, 100, 100, 0);
    chk("t1_nwords", wlog.size(), 3);
    chk("t1_w0", {wlog[0].a, wlog[0].d}, {8'h10, 32'h00221820});
    chk("t1_w1", {wlog[1].a, wlog[1].d}, {8'h11, 32'h8C040008});
    chk("t1_w2", {wlog[2].a, wlog[2].d}, {8'h12, 32'h08000040});
    chk("t1_count", count, 3);

    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back(rnd_req(1'b1));
    run(8'h40, 100, 100, 5);
    chk("t2_nwords", wlog.size(), 6);

    prog.delete();
    prog.push_back(mk(8, 1, 2, 0, 'hFFFF, 0));
    prog.push_back(mk(11, 0, 0, 0, 0, 'h3FFFFFF));
    run(8'h00, 100, 100, 0);
    chk("t3_w0", wlog[0].d, 32'h1022FFFF);
    chk("t3_w1", wlog[1].d, 32'h0FFFFFFF);

    prog.delete();
    prog.push_back(mk(0, 5, 6, 7, 0, 0));
    prog.push_back(mk(13, 1, 1, 1, 1, 1));
    prog.push_back(mk(1, 8, 9, 10, 0, 0));
    run(8'h20, 70, 70, 0);
    chk("t4_nwords", wlog.size(), 2);
    chk("t4_addr1", wlog[1].a, 8'h21);
    chk("t4_err", err, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_err_sticky", err, 1);
    @(posedge clk); #1;

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(rnd_req(1'b1));
    run(8'hFE, 100, 100, 0);
    chk("t5_a0", wlog[0].a, 8'hFE);
    chk("t5_a1", wlog[1].a, 8'hFF);
    chk("t5_a2", wlog[2].a, 8'h00);
    chk("t5_err", err, 1);

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(rnd_req(1'b1));
    start_addr = 8'h30;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      drive(prog[n], n == 2);
      bus.in_valid = 1'b1;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      if (bus.in_ready) n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("t6_accepted", n, 3);
    chk("t6_pre_we", bus.mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_in_ready", bus.in_ready, 0);
    chk("t6_mem_we", bus.mem_we, 0);
    chk("t6_mem_addr", bus.mem_addr, 0);
    chk("t6_mem_wdata", bus.mem_wdata, 0);
    chk("t6_count", count, 0);
    chk("t6_err", err, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(rnd_req(1'b0));
    run(8'h50, 80, 80, 0);

    for (int p = 0; p < 25; p++) begin
      prog.delete();
      n = 1 + $urandom % 8;
      for (int i = 0; i < n; i++) prog.push_back(rnd_req(1'b0));
      run(8'($urandom), 40 + $urandom % 61, 20 + $urandom % 81,
          ($urandom % 4 == 0) ? $urandom % 6 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
